mac_stream_cluster: RTL

Parametrised successor to the four-block MAC cluster.
- LANES independent signed/unsigned multiply-accumulate lanes behind a valid/ready stream interface.
- Each lane accumulates cfg_len products, starting from a per-lane initial value, then emits the dot-product result and reloads automatically.
- Optional saturation with per-lane sticky overflow.
- Sits between the operand fetch stream and the result writeback stream of the compute array.

---
 rtl/mac_stream_cluster_if.sv | 35 +++
 rtl/mac_stream_cluster.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mac_stream_cluster_if.sv
// Stream and configuration bundle for mac_stream_cluster.
// The slave modport is the MAC cluster; master is the fetch/writeback side driving it.
interface mac_stream_cluster_if #(
  parameter int LANES     = 4,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
);
  logic                           cset;
  logic                           cfg_signed;
  logic                           cfg_sat;
  logic [CNT_WIDTH-1:0]           cfg_len;
  logic [LANES*ACC_WIDTH-1:0]     cfg_init;
  logic                           in_valid;
  logic                           in_ready;
  logic [LANES*IN_WIDTH-1:0]      a;
  logic [LANES*IN_WIDTH-1:0]      b;
  logic                           out_valid;
  logic                           out_ready;
  logic [LANES*ACC_WIDTH-1:0]     out;
  logic [LANES-1:0]               out_ovf;
  logic                           busy;

  modport slave (
    input  cset, cfg_signed, cfg_sat, cfg_len, cfg_init,
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out, out_ovf, busy
  );

  modport master (
    output cset, cfg_signed, cfg_sat, cfg_len, cfg_init,
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, out_ovf, busy
  );
endinterface

// File: rtl/mac_stream_cluster.sv
// LANES-wide multiply-accumulate cluster: two-stage pipeline (multiply, accumulate),
// emits one dot-product per cfg_len beats, optional saturation with sticky overflow.
module mac_stream_cluster #(
  parameter int LANES     = 4,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mac_stream_cluster_if.slave  bus
);
  localparam int PW = 2 * IN_WIDTH;
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic                               signed_q, signed_d;
  logic                               sat_q, sat_d;
  logic [CNT_WIDTH-1:0]               len_q, len_d;
  logic [LANES-1:0][ACC_WIDTH-1:0]    init_q, init_d;
  logic [LANES-1:0][PW-1:0]           p_q, p_d;
  logic                               p_valid_q, p_valid_d;
  logic [LANES-1:0][ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [LANES-1:0]                   ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;
  logic [LANES-1:0][ACC_WIDTH-1:0]    out_q, out_d;
  logic [LANES-1:0]                   out_ovf_q, out_ovf_d;
  logic                               out_valid_q, out_valid_d;

  logic [LANES-1:0][PW-1:0]           prod_w;
  logic [LANES-1:0][ACC_WIDTH-1:0]    sum_w;
  logic [LANES-1:0]                   ovf_w;
  logic                               stall, accept, advance, last, busy, cfg_load;

  assign stall    = out_valid_q & ~bus.out_ready;
  assign accept   = bus.in_valid & ~stall;
  assign advance  = p_valid_q & ~stall;
  assign last     = (cnt_q == len_q - CNT_WIDTH'(1));
  assign busy     = p_valid_q | out_valid_q | (cnt_q != '0);
  assign cfg_load = bus.cset & ~busy;

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.busy      = busy;

  // Operands are extended to PW bits so a PW-bit product is exact in either signedness.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [PW-1:0]        ax, bx;
    logic [ACC_WIDTH:0]   accx, px, sf;

    assign ax = {{IN_WIDTH{signed_q & bus.a[g*IN_WIDTH+IN_WIDTH-1]}}, bus.a[g*IN_WIDTH +: IN_WIDTH]};
    assign bx = {{IN_WIDTH{signed_q & bus.b[g*IN_WIDTH+IN_WIDTH-1]}}, bus.b[g*IN_WIDTH +: IN_WIDTH]};
    assign prod_w[g] = ax * bx;

    assign px   = {{(ACC_WIDTH-PW+1){signed_q & p_q[g][PW-1]}}, p_q[g]};
    assign accx = {signed_q & acc_q[g][ACC_WIDTH-1], acc_q[g]};
    assign sf   = accx + px;

    // One guard bit: signed overflow when the top two bits disagree, unsigned on carry-out.
    assign ovf_w[g] = signed_q ? (sf[ACC_WIDTH] ^ sf[ACC_WIDTH-1]) : sf[ACC_WIDTH];
    assign sum_w[g] = !(sat_q & ovf_w[g]) ? sf[ACC_WIDTH-1:0] :
                      !signed_q           ? {ACC_WIDTH{1'b1}} :
                      sf[ACC_WIDTH]       ? SMIN : SMAX;
  end

  always_comb begin
    signed_d    = signed_q;
    sat_d       = sat_q;
    len_d       = len_q;
    init_d      = init_q;
    p_d         = p_q;
    p_valid_d   = p_valid_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (cfg_load) begin
      signed_d = bus.cfg_signed;
      sat_d    = bus.cfg_sat;
      len_d    = (bus.cfg_len == '0) ? CNT_WIDTH'(1) : bus.cfg_len;
      init_d   = bus.cfg_init;
      acc_d    = bus.cfg_init;
      ovf_d    = '0;
      cnt_d    = '0;
    end

    if (!stall) begin
      p_valid_d = accept;
    end
    if (accept) begin
      p_d = prod_w;
    end

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // advance implies busy, so it never coincides with a config load.
    if (advance) begin
      if (last) begin
        out_d       = sum_w;
        out_ovf_d   = ovf_q | ovf_w;
        out_valid_d = 1'b1;
        acc_d       = init_q;
        ovf_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = sum_w;
        ovf_d = ovf_q | ovf_w;
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signed_q    <= 1'b0;
      sat_q       <= 1'b0;
      len_q       <= CNT_WIDTH'(1);
      init_q      <= '0;
      p_q         <= '0;
      p_valid_q   <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_ovf_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      signed_q    <= signed_d;
      sat_q       <= sat_d;
      len_q       <= len_d;
      init_q      <= init_d;
      p_q         <= p_d;
      p_valid_q   <= p_valid_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
